kernel_fetch_scheduler: RTL and testbench

KERNEL_FETCH_SCHEDULER -- requirements
Module: kernel_fetch_scheduler

---
 rtl/kernel_loader_pkg.sv | 16 +
 rtl/kl_rr_arbiter.sv | 33 +++
 rtl/kernel_fetch_scheduler.sv | 162 ++++++++++++++++
 tb/tb_kernel_fetch_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kernel_loader_pkg.sv
// Shared constants and FSM state encoding for the kernel fetch scheduler.
package kernel_loader_pkg;

  localparam int unsigned NUM_KERNELS     = 5;
  localparam int unsigned BYTES_PER_BURST = 64;
  localparam int unsigned SEL_W           = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    FIN   = 3'd4
  } state_e;

endpackage

// File: rtl/kl_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after i_ptr.
module kl_rr_arbiter
  import kernel_loader_pkg::*;
#(
  parameter int unsigned N     = NUM_KERNELS,
  parameter int unsigned IDX_W = SEL_W
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt_c,
  output logic [IDX_W-1:0] o_idx_c,
  output logic             o_any_c
);

  logic [IDX_W-1:0] w_k;

  always_comb begin
    o_gnt_c = '0;
    o_idx_c = '0;
    o_any_c = 1'b0;
    w_k     = '0;
    // Search order starts one past the last granted channel.
    for (int unsigned i = 1; i <= N; i++) begin
      w_k = IDX_W'((32'(i_ptr) + i) % N);
      if (!o_any_c && i_req[w_k]) begin
        o_gnt_c[w_k] = 1'b1;
        o_idx_c      = w_k;
        o_any_c      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/kernel_fetch_scheduler.sv
// Round-robin burst command scheduler feeding per-kernel FIFOs from memory;
// one burst outstanding at a time.
module kernel_fetch_scheduler #(
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 64,
  parameter int unsigned C_S_AXI_BURST_LEN  = 8,
  parameter int unsigned FIFO_DEPTH         = 64,
  parameter int unsigned NUM_KERNELS        = kernel_loader_pkg::NUM_KERNELS
) (
  input  logic                                       clk,
  input  logic                                       reset_n,
  input  logic                                       Start,
  input  logic                                       Stop,
  input  logic [NUM_KERNELS-1:0]                     skip_en,
  input  logic [NUM_KERNELS*C_S_AXI_ADDR_WIDTH-1:0]  kernel_start_addr,
  input  logic [NUM_KERNELS*C_S_AXI_ADDR_WIDTH-1:0]  kernel_end_addr,
  input  logic [NUM_KERNELS-1:0]                     kernel_wrap_en,
  input  logic [NUM_KERNELS*8-1:0]                   kernel_fifo_count,
  output logic                                       cmd_valid,
  input  logic                                       cmd_ready,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]              cmd_addr,
  output logic [7:0]                                 cmd_len,
  output logic [2:0]                                 cmd_sel,
  input  logic                                       burst_done,
  output logic                                       busy,
  output logic                                       done
);

  import kernel_loader_pkg::*;

  localparam int unsigned   AW          = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned   N           = NUM_KERNELS;
  localparam int unsigned   BURST_BYTES = (C_S_AXI_DATA_WIDTH / 8) * C_S_AXI_BURST_LEN;
  localparam logic [AW-1:0] ADDR_MASK   = ~AW'(BYTES_PER_BURST - 1);
  localparam logic [8:0]    DEPTH9      = 9'(FIFO_DEPTH);
  localparam logic [8:0]    BURST9      = 9'(C_S_AXI_BURST_LEN);

  state_e              r_state, w_next;
  logic [AW-1:0]       r_cur_addr [N];
  logic [N-1:0]        r_fin;
  logic                r_stop;
  logic [SEL_W-1:0]    r_rr_ptr;
  logic                r_cmd_valid, r_busy, r_done;
  logic [AW-1:0]       r_cmd_addr;
  logic [SEL_W-1:0]    r_cmd_sel;

  logic [AW-1:0]       w_start [N];
  logic [AW-1:0]       w_end   [N];
  logic [N-1:0]        w_elig, w_gnt, w_init_fin, w_fin_upd;
  logic [SEL_W-1:0]    w_gnt_idx;
  logic                w_gnt_any;
  logic [AW-1:0]       w_gnt_addr, w_adv;
  logic                w_past_end, w_stop, w_grant;

  assign cmd_valid = r_cmd_valid;
  assign cmd_addr  = r_cmd_addr;
  assign cmd_sel   = r_cmd_sel;
  assign cmd_len   = 8'(C_S_AXI_BURST_LEN - 1);
  assign busy      = r_busy;
  assign done      = r_done;

  // Per-channel burst-aligned address window and FIFO headroom check.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      w_start[k]    = kernel_start_addr[k*AW +: AW] & ADDR_MASK;
      w_end[k]      = kernel_end_addr[k*AW +: AW] & ADDR_MASK;
      w_init_fin[k] = skip_en[k] | (w_start[k] == w_end[k]);
      w_elig[k]     = ~r_fin[k] &
                      ((DEPTH9 - {1'b0, kernel_fifo_count[k*8 +: 8]}) >= BURST9);
    end
  end

  kl_rr_arbiter #(
    .N     (N),
    .IDX_W (SEL_W)
  ) u_arb (
    .i_req   (w_elig),
    .i_ptr   (r_rr_ptr),
    .o_gnt_c (w_gnt),
    .o_idx_c (w_gnt_idx),
    .o_any_c (w_gnt_any)
  );

  always_comb begin
    w_gnt_addr = '0;
    for (int k = 0; k < N; k++) begin
      if (w_gnt[k]) w_gnt_addr = w_gnt_addr | r_cur_addr[k];
    end
  end

  // Address advance for the channel whose burst is in flight.
  always_comb begin
    w_adv      = r_cur_addr[r_cmd_sel] + AW'(BURST_BYTES);
    w_past_end = (w_adv >= w_end[r_cmd_sel]);
    w_fin_upd  = r_fin;
    if (w_past_end && !kernel_wrap_en[r_cmd_sel]) w_fin_upd[r_cmd_sel] = 1'b1;
    w_stop     = r_stop | Stop;
  end

  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    case (r_state)
      IDLE:  if (Start) w_next = SCAN;
      SCAN: begin
        if (w_stop || (&r_fin)) begin
          w_next = FIN;
        end else if (w_gnt_any) begin
          w_next  = ISSUE;
          w_grant = 1'b1;
        end
      end
      ISSUE: if (cmd_ready) w_next = WAIT;
      WAIT: begin
        if (burst_done) w_next = (w_stop || (&w_fin_upd)) ? FIN : SCAN;
      end
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_fin       <= '0;
      r_stop      <= 1'b0;
      r_rr_ptr    <= SEL_W'(N - 1);
      r_cmd_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_sel   <= '0;
      for (int k = 0; k < N; k++) r_cur_addr[k] <= '0;
    end else begin
      r_state     <= w_next;
      r_cmd_valid <= (w_next == ISSUE);
      r_busy      <= (w_next != IDLE);
      r_done      <= (w_next == FIN);

      if (r_state == IDLE) r_stop <= 1'b0;
      else if (Stop)       r_stop <= 1'b1;

      if (r_state == IDLE && Start) begin
        r_fin <= w_init_fin;
        for (int k = 0; k < N; k++) r_cur_addr[k] <= w_start[k];
      end

      if (w_grant) begin
        r_cmd_addr <= w_gnt_addr;
        r_cmd_sel  <= w_gnt_idx;
        r_rr_ptr   <= w_gnt_idx;
      end

      if (r_state == WAIT && burst_done) begin
        r_fin <= w_fin_upd;
        if (!w_past_end)                  r_cur_addr[r_cmd_sel] <= w_adv;
        else if (kernel_wrap_en[r_cmd_sel]) r_cur_addr[r_cmd_sel] <= w_start[r_cmd_sel];
      end
    end
  end

endmodule

// File: tb/tb_kernel_fetch_scheduler.sv
// Self-checking bench for kernel_fetch_scheduler: directed scenarios plus
// randomized runs checked against a command-sequence reference model.
module tb_kernel_fetch_scheduler;

  localparam int unsigned N  = 5;
  localparam int unsigned AW = 32;
  localparam int R_ALLFIN = 0;
  localparam int R_LIMIT  = 1;
  localparam int R_STUCK  = 2;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            Start = 1'b0, Stop = 1'b0, cmd_ready = 1'b0, burst_done = 1'b0;
  logic [N-1:0]    skip_en = '0, kernel_wrap_en = '0;
  logic [N*AW-1:0] kernel_start_addr = '0, kernel_end_addr = '0;
  logic [N*8-1:0]  kernel_fifo_count = '0;
  logic            cmd_valid, busy, done;
  logic [AW-1:0]   cmd_addr;
  logic [7:0]      cmd_len;
  logic [2:0]      cmd_sel;

  kernel_fetch_scheduler dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .Start             (Start),
    .Stop              (Stop),
    .skip_en           (skip_en),
    .kernel_start_addr (kernel_start_addr),
    .kernel_end_addr   (kernel_end_addr),
    .kernel_wrap_en    (kernel_wrap_en),
    .kernel_fifo_count (kernel_fifo_count),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_addr          (cmd_addr),
    .cmd_len           (cmd_len),
    .cmd_sel           (cmd_sel),
    .burst_done        (burst_done),
    .busy              (busy),
    .done              (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] c_start [N];
  logic [31:0] c_end   [N];
  logic [7:0]  c_cnt   [N];
  logic [N-1:0] c_skip, c_wrap;
  int          m_ptr = 4;
  logic [31:0] e_addr [$];
  int          e_sel  [$];
  int          e_reason;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; Start = 1'b0; Stop = 1'b0; cmd_ready = 1'b0; burst_done = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    m_ptr = 4;
    tick();
  endtask

  task automatic clear_cfg();
    for (int k = 0; k < N; k++) begin
      c_start[k] = '0; c_end[k] = '0; c_cnt[k] = '0;
    end
    c_skip = '1; c_wrap = '0;
  endtask

  task automatic apply_cfg();
    for (int k = 0; k < N; k++) begin
      kernel_start_addr[k*AW +: AW] = c_start[k];
      kernel_end_addr[k*AW +: AW]   = c_end[k];
      kernel_fifo_count[k*8 +: 8]   = c_cnt[k];
    end
    skip_en        = c_skip;
    kernel_wrap_en = c_wrap;
  endtask

  // Expected command list: round-robin over channels with room for a burst.
  task automatic model_run(input int max_cmds);
    logic [31:0] cur [N];
    logic [31:0] s, e;
    bit          fin [N];
    bit          allf;
    int          cnt, g, k;
    e_addr.delete(); e_sel.delete();
    cnt = 0;
    for (int i = 0; i < N; i++) begin
      cur[i] = c_start[i] & ~32'h3F;
      fin[i] = c_skip[i] || ((c_start[i] & ~32'h3F) == (c_end[i] & ~32'h3F));
    end
    while (1) begin
      allf = 1;
      for (int i = 0; i < N; i++) if (!fin[i]) allf = 0;
      if (allf) begin e_reason = R_ALLFIN; break; end
      if (cnt == max_cmds) begin e_reason = R_LIMIT; break; end
      g = -1;
      for (int i = 1; i <= N; i++) begin
        k = (m_ptr + i) % N;
        if (g < 0 && !fin[k] && (64 - int'(c_cnt[k])) >= 8) g = k;
      end
      if (g < 0) begin e_reason = R_STUCK; break; end
      e_addr.push_back(cur[g]);
      e_sel.push_back(g);
      m_ptr = g;
      cnt++;
      s = c_start[g] & ~32'h3F;
      e = c_end[g] & ~32'h3F;
      cur[g] = cur[g] + 32'd64;
      if (cur[g] >= e) begin
        if (c_wrap[g]) cur[g] = s;
        else           fin[g] = 1;
      end
    end
  endtask

  // Acts as the burst reader for one run; stall < 0 picks a random stall.
  task automatic run(input int max_cmds, input int bd_gap, input int stall, input string tag);
    int  w, st, stray;
    bit  stable, idle_ok;
    logic [31:0] a;
    logic [2:0]  s;
    model_run(max_cmds);
    apply_cfg();
    Start = 1'b1; tick(); Start = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    if (e_addr.size() == 0 && e_reason == R_ALLFIN) begin
      check({tag, "_done_early"}, 64'(done), 64'd0);
      tick();
      check({tag, "_done"}, 64'(done), 64'd1);
      tick();
      check({tag, "_done_pulse"}, 64'(done), 64'd0);
      return;
    end
    foreach (e_addr[j]) begin
      w = 0;
      while (!cmd_valid && !done && w < 60) begin tick(); w++; end
      check($sformatf("%s_valid%0d", tag, j), 64'(cmd_valid), 64'd1);
      if (!cmd_valid) begin do_reset(); return; end
      check($sformatf("%s_addr%0d", tag, j), 64'(cmd_addr), 64'(e_addr[j]));
      check($sformatf("%s_sel%0d", tag, j), 64'(cmd_sel), 64'(e_sel[j]));
      check($sformatf("%s_len%0d", tag, j), 64'(cmd_len), 64'd7);
      st = (stall < 0) ? int'($urandom_range(3, 0)) : stall;
      if (st > 0) begin
        a = cmd_addr; s = cmd_sel; stable = 1;
        stray = int'($urandom_range(st - 1, 0));
        for (int c = 0; c < st; c++) begin
          burst_done = (c == stray);
          tick();
          burst_done = 1'b0;
          if (!(cmd_valid && cmd_addr == a && cmd_sel == s)) stable = 0;
        end
        check($sformatf("%s_stall_stable%0d", tag, j), 64'(stable), 64'd1);
      end
      cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
      idle_ok = 1;
      for (int d = 0; d < bd_gap; d++) begin
        if (j == e_addr.size() - 1 && e_reason == R_LIMIT && d == 0) Stop = 1'b1;
        tick();
        Stop = 1'b0;
        if (cmd_valid || done) idle_ok = 0;
      end
      check($sformatf("%s_one_outstanding%0d", tag, j), 64'(idle_ok), 64'd1);
      burst_done = 1'b1; tick(); burst_done = 1'b0;
    end
    if (e_reason == R_STUCK) begin
      idle_ok = 1;
      repeat (5) begin tick(); if (cmd_valid || done) idle_ok = 0; end
      check({tag, "_stuck_quiet"}, 64'(idle_ok), 64'd1);
      Stop = 1'b1; tick(); Stop = 1'b0;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    tick();
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int  w;
    bit  quiet;
    int  nb;

    clear_cfg();
    do_reset();
    check("rst_valid", 64'(cmd_valid), 64'd0);
    check("rst_busy",  64'(busy),      64'd0);
    check("rst_done",  64'(done),      64'd0);
    check("rst_addr",  64'(cmd_addr),  64'd0);
    check("rst_sel",   64'(cmd_sel),   64'd0);
    check("rst_len",   64'(cmd_len),   64'd7);

    clear_cfg();
    run(1000, 4, 0, "allskip");

    // Channel 0 walks 0x1000..0x2000 in 64 bursts.
    do_reset(); clear_cfg();
    c_skip = 5'b11110; c_start[0] = 32'h1000; c_end[0] = 32'h2000;
    run(1000, 4, 0, "ch0_walk");

    // Two channels interleave.
    do_reset(); clear_cfg();
    c_skip = 5'b11100;
    c_start[0] = 32'h1000; c_end[0] = 32'h1080;
    c_start[1] = 32'h3000; c_end[1] = 32'h3080;
    run(1000, 4, 0, "rr_pair");

    // Full FIFO blocks the channel until space opens up.
    do_reset(); clear_cfg();
    c_skip = 5'b11110; c_start[0] = 32'h1000; c_end[0] = 32'h1040; c_cnt[0] = 8'h40;
    apply_cfg();
    Start = 1'b1; tick(); Start = 1'b0;
    quiet = 1;
    repeat (100) begin tick(); if (cmd_valid) quiet = 0; end
    check("full_quiet", 64'(quiet), 64'd1);
    c_cnt[0] = 8'h38; apply_cfg();
    w = 0;
    while (!cmd_valid && w < 2) begin tick(); w++; end
    check("unblock_valid", 64'(cmd_valid), 64'd1);
    check("unblock_sel",   64'(cmd_sel),   64'd0);
    check("unblock_addr",  64'(cmd_addr),  64'h1000);
    cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
    tick();
    burst_done = 1'b1; tick(); burst_done = 1'b0;
    check("unblock_done", 64'(done), 64'd1);
    tick();
    check("unblock_done_pulse", 64'(done), 64'd0);

    // Wrapping channel 2 ended by Stop.
    do_reset(); clear_cfg();
    c_skip = 5'b11011; c_wrap = 5'b00100; c_start[2] = 32'h0; c_end[2] = 32'h80;
    run(5, 4, 0, "wrap_stop");

    // Long back-pressure with a stray burst_done while issuing.
    do_reset(); clear_cfg();
    c_skip = 5'b11110; c_start[0] = 32'h1000; c_end[0] = 32'h1080;
    run(1000, 4, 20, "stall");

    // Reset while a burst is outstanding.
    do_reset(); clear_cfg();
    c_skip = 5'b11110; c_start[0] = 32'h1000; c_end[0] = 32'h1100;
    apply_cfg();
    Start = 1'b1; tick(); Start = 1'b0;
    w = 0;
    while (!cmd_valid && w < 10) begin tick(); w++; end
    check("midrst_valid", 64'(cmd_valid), 64'd1);
    cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("midrst_valid0", 64'(cmd_valid), 64'd0);
    check("midrst_busy0",  64'(busy),      64'd0);
    check("midrst_done0",  64'(done),      64'd0);
    check("midrst_addr0",  64'(cmd_addr),  64'd0);
    check("midrst_sel0",   64'(cmd_sel),   64'd0);
    check("midrst_len",    64'(cmd_len),   64'd7);
    tick();
    reset_n = 1'b1; m_ptr = 4;
    tick();
    run(1000, 4, 0, "after_rst");

    // Randomized runs; the round-robin pointer carries across runs.
    do_reset();
    for (int r = 0; r < 25; r++) begin
      clear_cfg();
      for (int k = 0; k < N; k++) begin
        c_skip[k]  = ($urandom_range(3, 0) == 0);
        c_wrap[k]  = ($urandom_range(4, 0) == 0);
        c_start[k] = (32'($urandom_range(15, 0)) << 12) + (32'($urandom) & 32'h3FF);
        nb         = int'($urandom_range(3, 0));
        c_end[k]   = (c_start[k] & ~32'h3F) + 32'(nb * 64) + 32'($urandom_range(63, 0));
        c_cnt[k]   = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(64, 57))
                                                 : 8'($urandom_range(56, 0));
      end
      run(int'($urandom_range(12, 1)), int'($urandom_range(4, 1)), -1,
          $sformatf("rand%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
